mult_arb_16: RTL and testbench
==============================

# mult_arb_16

Arbiter and sequencer that shares one sequential 16-bit shift-add multiplier (17-cycle, start/ready controlled) between two requesters. It accepts operand pairs through a req/gnt handshake, latches them, starts the multiplier, waits for its ready flag and returns the 32-bit product with a per-requester done pulse. After each result it clears the multiplier back to its idle count. It sits between the ALU issue logic and the multiplier datapath, with a watchdog against a hung multiplier.

## Interface
- WIDTH, 16, operand width; product is 2*WIDTH
- TIMEOUT, 24, max BUSY cycles waiting for m_ready before abort
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- req0 / req1  in  1  request, held with operands until gnt
- a0, b0 / a1, b1  in  WIDTH  multiplicand / multiplier per requester
- gnt0 / gnt1  out  1  operands accepted this cycle (Mealy, IDLE only)
- done0 / done1  out  1  one-cycle pulse: product valid for that requester
- err0 / err1  out  1  one-cycle pulse: watchdog abort for that requester
- product  out  2*WIDTH  last captured product, held until next capture
- busy  out  1  state != IDLE
- m_a, m_b  out  WIDTH  latched operands to multiplier
- m_start  out  1  multiplier multOp
- m_clear  out  1  multiplier reset: reset OR state in {DONE, ABORT}
- m_ready  in  1  multiplier ready (stays high until cleared)
- m_product  in  2*WIDTH  multiplier result

## Operation
- States: IDLE, START, BUSY, DONE, ABORT.
- IDLE:
  - If exactly one req is high, grant it.
  - If both are high, grant the requester selected by `prio` (1-bit round-robin pointer).
  - gnt_x is asserted combinationally in this cycle. At the edge: latch a_x/b_x into m_a/m_b, latch `owner`=x, go START.
  - With no req, stay in IDLE.
- START: m_start=1 for exactly one cycle; clear watchdog; go BUSY.
- BUSY: m_start=0.
  - If m_ready: capture m_product into product, go DONE.
  - Else if watchdog == TIMEOUT-1: go ABORT.
  - Else watchdog++.
- DONE: done_owner=1, m_clear=1, prio <= ~owner; go IDLE.
- ABORT: err_owner=1, m_clear=1, product unchanged, prio <= ~owner; go IDLE.
- m_a/m_b hold the latched values from grant until the next grant.
- Req dropped before gnt: no grant, no side effect. Req and gnt are never asserted in non-IDLE states.
- The same requester may re-request immediately. It wins if the other is idle; if the other is also requesting, it loses to the other.
- Reset (any time, including mid-BUSY):
  - Immediately: state=IDLE, prio=0, owner=0, product=0, m_a=m_b=0, watchdog=0.
  - All gnt/done/err/m_start=0; busy=0.
  - m_clear=1 while reset is high.
- Products are unsigned; no truncation (full 2*WIDTH).

## Timing
- gnt at cycle T, START at T+1, multiplier count 1..17 at T+2..T+18.
- m_ready is first seen at T+18, product is registered, done pulses at T+19.
- product is valid from T+19; IDLE at T+20; next grant is possible at T+20.
- Minimum issue interval: 20 cycles per operation.
- Abort: err pulses at T+2+TIMEOUT; IDLE one cycle later.
- done, err and gnt are single-cycle pulses; done and err are never both high.

## Structure
- Package mult_arb_pkg: state enum (IDLE, START, BUSY, DONE, ABORT), WIDTH default, watchdog width = $clog2(TIMEOUT).
- Sub-module mult_arb_rr: 2-way round-robin picker (req0, req1, prio -> gnt0, gnt1, grant index).
- FSM, operand/product registers and watchdog live in mult_arb_16.
- The bench uses a behavioural 17-cycle multiplier model with optional ready suppression.

## Test plan
- req0, a0=16'd300, b0=16'd7 -> gnt0 at T, done0 at T+19, product=32'd2100, busy low at T+20.
- req0 and req1 together, a0=3/b0=5, a1=16'hFFFF/b1=16'hFFFF:
  - done0 first with product 15.
  - gnt1 at its IDLE; done1 with product 32'hFFFE0001.
  - prio returns to 0.
- req0 held continuously with req1 asserted mid-operation -> next grant goes to requester 1, then to 0, strictly alternating.
- Model never asserts ready -> err0 pulse exactly TIMEOUT+2 cycles after gnt0, m_clear high that cycle, product unchanged, IDLE next.
- Assert reset at BUSY cycle 8 -> all outputs 0 immediately, m_clear high during reset, no done. A fresh req after release completes normally with the correct product.
- req1 pulsed one cycle while busy -> never granted, no done1.

Source files
------------

// File: rtl/mult_arb_pkg.sv
// Shared constants and state encoding for the two-port multiplier arbiter.
// State codes are plain constants so legacy tools and waveform viewers see raw values.
package mult_arb_pkg;

    localparam int DEF_WIDTH   = 16;
    localparam int DEF_TIMEOUT = 24;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_START = 3'd1;
    localparam state_t ST_BUSY  = 3'd2;
    localparam state_t ST_DONE  = 3'd3;
    localparam state_t ST_ABORT = 3'd4;

    // Watchdog counts 0..timeout-1, so a width of clog2(timeout) suffices.
    function automatic int wd_width(input int timeout);
        return (timeout > 1) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/mult_arb_rr.sv
// Two-way round-robin picker: a lone request always wins, a tie goes to i_prio.
module mult_arb_rr (
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_prio,
    output logic o_gnt0,
    output logic o_gnt1,
    output logic o_idx
);

    always_comb begin
        o_gnt0 = i_req0 && (!i_req1 || !i_prio);
        o_gnt1 = i_req1 && (!i_req0 ||  i_prio);
        o_idx  = o_gnt1;
    end

endmodule

// File: rtl/mult_arb_16.sv
// Shares one start/ready sequential multiplier between two requesters, with a
// round-robin grant, operand/product registers and a watchdog against a hung multiplier.
module mult_arb_16
    import mult_arb_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req0,
    input  logic [WIDTH-1:0]   a0,
    input  logic [WIDTH-1:0]   b0,
    input  logic               req1,
    input  logic [WIDTH-1:0]   a1,
    input  logic [WIDTH-1:0]   b1,
    output logic               gnt0,
    output logic               gnt1,
    output logic               done0,
    output logic               done1,
    output logic               err0,
    output logic               err1,
    output logic [2*WIDTH-1:0] product,
    output logic               busy,
    output logic [WIDTH-1:0]   m_a,
    output logic [WIDTH-1:0]   m_b,
    output logic               m_start,
    output logic               m_clear,
    input  logic               m_ready,
    input  logic [2*WIDTH-1:0] m_product
);

    localparam int              WD_W    = wd_width(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    state_t               r_state;
    logic                 r_prio;
    logic                 r_owner;
    logic [2*WIDTH-1:0]   r_product;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [WD_W-1:0]      r_wd;

    logic w_rr_gnt0;
    logic w_rr_gnt1;
    logic w_rr_idx;
    logic w_idle;

    mult_arb_rr u_rr (
        .i_req0 (req0),
        .i_req1 (req1),
        .i_prio (r_prio),
        .o_gnt0 (w_rr_gnt0),
        .o_gnt1 (w_rr_gnt1),
        .o_idx  (w_rr_idx)
    );

    // Grants are Mealy and must stay low while reset is held, even though state is IDLE.
    always_comb begin
        w_idle  = (r_state == ST_IDLE) && !reset;
        gnt0    = w_idle && w_rr_gnt0;
        gnt1    = w_idle && w_rr_gnt1;
        done0   = (r_state == ST_DONE)  && !r_owner;
        done1   = (r_state == ST_DONE)  &&  r_owner;
        err0    = (r_state == ST_ABORT) && !r_owner;
        err1    = (r_state == ST_ABORT) &&  r_owner;
        busy    = (r_state != ST_IDLE);
        m_start = (r_state == ST_START);
        m_clear = reset || (r_state == ST_DONE) || (r_state == ST_ABORT);
        product = r_product;
        m_a     = r_a;
        m_b     = r_b;
    end

    // NOTE: every register here updates with <= so all of them see the same pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_prio    <= 1'b0;
            r_owner   <= 1'b0;
            r_product <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_wd      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_rr_gnt0 || w_rr_gnt1) begin
                        r_a     <= w_rr_idx ? a1 : a0;
                        r_b     <= w_rr_idx ? b1 : b0;
                        r_owner <= w_rr_idx;
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    r_wd    <= '0;
                    r_state <= ST_BUSY;
                end
                ST_BUSY: begin
                    if (m_ready) begin
                        r_product <= m_product;
                        r_state   <= ST_DONE;
                    end else if (r_wd == WD_LAST) begin
                        r_state <= ST_ABORT;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
                end
                ST_DONE, ST_ABORT: begin
                    r_prio  <= ~r_owner;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_arb_16.sv
// Directed bench for mult_arb_16 with a behavioural 17-cycle start/ready multiplier.
module tb_mult_arb_16;

    logic        clk;
    logic        reset;
    logic        req0, req1;
    logic [15:0] a0, b0, a1, b1;
    logic        gnt0, gnt1, done0, done1, err0, err1;
    logic [31:0] product;
    logic        busy;
    logic [15:0] m_a, m_b;
    logic        m_start, m_clear, m_ready;
    logic [31:0] m_product;

    logic        suppress;
    logic [5:0]  mcnt;
    logic [31:0] mprod;

    int n_cmp;
    int n_mis;

    mult_arb_16 dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .a0        (a0),
        .b0        (b0),
        .req1      (req1),
        .a1        (a1),
        .b1        (b1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .done0     (done0),
        .done1     (done1),
        .err0      (err0),
        .err1      (err1),
        .product   (product),
        .busy      (busy),
        .m_a       (m_a),
        .m_b       (m_b),
        .m_start   (m_start),
        .m_clear   (m_clear),
        .m_ready   (m_ready),
        .m_product (m_product)
    );

    always #5 clk = ~clk;

    // Multiplier model: count 1..17 after start, ready at 17 until cleared.
    always @(posedge clk) begin
        if (m_clear) begin
            mcnt <= 6'd0;
        end else if (m_start) begin
            mcnt  <= 6'd1;
            mprod <= 32'(m_a) * 32'(m_b);
        end else if (mcnt != 6'd0 && mcnt < 6'd17) begin
            mcnt <= mcnt + 6'd1;
        end
    end
    assign m_ready   = (mcnt == 6'd17) && !suppress;
    assign m_product = mprod;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        req0  = 1'b0;
        req1  = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Waits for the first done/err pulse; lat is the cycle index relative to the grant.
    task automatic wait_evt(input int start, output int lat, output logic [3:0] ev);
        lat = -1;
        ev  = 4'b0000;
        for (int k = start; k < start + 60; k++) begin
            @(posedge clk);
            #2;
            if ({err1, err0, done1, done0} != 4'b0000) begin
                lat = k;
                ev  = {err1, err0, done1, done0};
                return;
            end
        end
    endtask

    // who: 0/1 granted requester, 2 both granted, 3 none within the bound.
    task automatic wait_gnt(output int who);
        who = 3;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #2;
            if (gnt0 && gnt1) begin
                who = 2;
                return;
            end else if (gnt0 || gnt1) begin
                who = gnt1 ? 1 : 0;
                return;
            end
        end
    endtask

    initial begin
        int         lat;
        int         who;
        int         bad;
        logic [3:0] ev;

        n_cmp = 0;
        n_mis = 0;
        clk = 1'b0;
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        suppress = 1'b0;

        #1;
        check_val("rst_busy",    64'(busy),    64'd0);
        check_val("rst_mclear",  64'(m_clear), 64'd1);
        check_val("rst_product", 64'(product), 64'd0);
        check_val("rst_ma",      64'(m_a),     64'd0);
        check_val("rst_mstart",  64'(m_start), 64'd0);
        check_val("rst_pulses",  64'({gnt0, gnt1, done0, done1, err0, err1}), 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1 check_val("rel_mclear", 64'(m_clear), 64'd0);

        // Single request 300*7
        @(posedge clk);
        #1 req0 = 1'b1; a0 = 16'd300; b0 = 16'd7;
        #1 check_val("t1_gnt", 64'({gnt0, gnt1}), 64'b10);
        @(posedge clk);
        #1 req0 = 1'b0;
        #1 check_val("t1_mstart", 64'(m_start), 64'd1);
        check_val("t1_mab", 64'({m_a, m_b}), 64'({16'd300, 16'd7}));
        wait_evt(2, lat, ev);
        check_val("t1_lat",     64'(lat),     64'd19);
        check_val("t1_ev",      64'(ev),      64'b0001);
        check_val("t1_product", 64'(product), 64'd2100);
        check_val("t1_mclear",  64'(m_clear), 64'd1);
        @(posedge clk);
        #2 check_val("t1_idle", 64'(busy), 64'd0);

        // Simultaneous requests, prio 0 after reset
        do_reset();
        req0 = 1'b1; a0 = 16'd3; b0 = 16'd5;
        req1 = 1'b1; a1 = 16'hFFFF; b1 = 16'hFFFF;
        #1 check_val("t2_gnt_first", 64'({gnt0, gnt1}), 64'b10);
        @(posedge clk);
        #1 req0 = 1'b0;
        #1 wait_evt(2, lat, ev);
        check_val("t2_lat0",  64'(lat),     64'd19);
        check_val("t2_ev0",   64'(ev),      64'b0001);
        check_val("t2_prod0", 64'(product), 64'd15);
        @(posedge clk);
        #2 check_val("t2_gnt_second", 64'({gnt0, gnt1}), 64'b01);
        check_val("t2_idle", 64'(busy), 64'd0);
        @(posedge clk);
        #1 req1 = 1'b0;
        #1 check_val("t2_ma1", 64'(m_a), 64'hFFFF);
        wait_evt(2, lat, ev);
        check_val("t2_lat1",  64'(lat),     64'd19);
        check_val("t2_ev1",   64'(ev),      64'b0010);
        check_val("t2_prod1", 64'(product), 64'hFFFE0001);
        @(posedge clk);
        #1 req0 = 1'b1; req1 = 1'b1;
        #1 check_val("t2_prio_back", 64'({gnt0, gnt1}), 64'b10);

        // req0 held, req1 joins mid-operation: strict alternation
        do_reset();
        req0 = 1'b1; a0 = 16'd2; b0 = 16'd3;
        a1 = 16'd4; b1 = 16'd5;
        #1 check_val("t3_gnt_a", 64'({gnt0, gnt1}), 64'b10);
        @(posedge clk);
        #1 req1 = 1'b1;
        wait_gnt(who);
        check_val("t3_gnt_b",  64'(who),     64'd1);
        check_val("t3_prod_b", 64'(product), 64'd6);
        wait_gnt(who);
        check_val("t3_gnt_c",  64'(who),     64'd0);
        check_val("t3_prod_c", 64'(product), 64'd20);
        wait_gnt(who);
        check_val("t3_gnt_d",  64'(who),     64'd1);
        check_val("t3_prod_d", 64'(product), 64'd6);

        // Watchdog abort keeps the previous product
        do_reset();
        req0 = 1'b1; a0 = 16'd300; b0 = 16'd7;
        @(posedge clk);
        #1 req0 = 1'b0;
        #1 wait_evt(2, lat, ev);
        check_val("t4_pre_product", 64'(product), 64'd2100);
        @(posedge clk);
        #1 suppress = 1'b1; req0 = 1'b1; a0 = 16'd9; b0 = 16'd9;
        #1 check_val("t4_gnt", 64'({gnt0, gnt1}), 64'b10);
        @(posedge clk);
        #1 req0 = 1'b0;
        #1 wait_evt(2, lat, ev);
        check_val("t4_lat",     64'(lat),     64'd26);
        check_val("t4_ev",      64'(ev),      64'b0100);
        check_val("t4_mclear",  64'(m_clear), 64'd1);
        check_val("t4_product", 64'(product), 64'd2100);
        @(posedge clk);
        #2 check_val("t4_idle", 64'({busy, err0}), 64'd0);
        suppress = 1'b0;

        // Reset in the middle of BUSY, then a fresh request
        do_reset();
        req1 = 1'b1; a1 = 16'd1000; b1 = 16'd1000;
        #1 check_val("t5_gnt1", 64'({gnt0, gnt1}), 64'b01);
        @(posedge clk);
        #1 req1 = 1'b0;
        repeat (8) @(posedge clk);
        #1 reset = 1'b1; req0 = 1'b1; a0 = 16'd1234; b0 = 16'd567;
        #1 check_val("t5_busy",   64'(busy),    64'd0);
        check_val("t5_mclear",    64'(m_clear), 64'd1);
        check_val("t5_mab",       64'({m_a, m_b}), 64'd0);
        check_val("t5_pulses",    64'({gnt0, gnt1, done0, done1, err0, err1, m_start}), 64'd0);
        @(posedge clk);
        #2 check_val("t5_mclear_hold", 64'(m_clear), 64'd1);
        @(posedge clk);
        #1 reset = 1'b0;
        #1 check_val("t5_fresh_gnt", 64'({gnt0, gnt1}), 64'b10);
        @(posedge clk);
        #1 req0 = 1'b0;
        #1 wait_evt(2, lat, ev);
        check_val("t5_lat",     64'(lat),     64'd19);
        check_val("t5_ev",      64'(ev),      64'b0001);
        check_val("t5_product", 64'(product), 64'd699678);

        // req1 pulsed for one cycle while busy is ignored
        do_reset();
        req0 = 1'b1; a0 = 16'd12; b0 = 16'd11;
        #1 check_val("t6_gnt0", 64'({gnt0, gnt1}), 64'b10);
        @(posedge clk);
        #1 req0 = 1'b0;
        repeat (3) @(posedge clk);
        #1 req1 = 1'b1; a1 = 16'd5; b1 = 16'd5;
        @(posedge clk);
        #1 req1 = 1'b0;
        wait_evt(6, lat, ev);
        check_val("t6_lat",     64'(lat),     64'd19);
        check_val("t6_ev",      64'(ev),      64'b0001);
        check_val("t6_product", 64'(product), 64'd132);
        bad = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #2;
            if (gnt1 || done1 || busy) bad++;
        end
        check_val("t6_no_req1", 64'(bad), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
